fp16_mul_arbiter: RTL and testbench



---
 rtl/fp16_pkg.sv | 11 +
 rtl/fp16_tag_fifo.sv | 50 +++++
 rtl/fp16_mul_arbiter.sv | 128 ++++++++++++
 tb/tb_fp16_mul_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 definitions used by the multiplier front-end blocks.
package fp16_pkg;

  localparam int FP16_W = 16;

  typedef logic [FP16_W-1:0] fp16_t;

  // Maximum number of operations the fp16_mul pipeline can hold at once.
  localparam int MUL_INFLIGHT = 3;

endpackage

// File: rtl/fp16_tag_fifo.sv
// Tag FIFO: records the requester ID of every issued multiply, oldest at the head.
module fp16_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [W-1:0]  o_head,
  output logic [AW:0]   o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Round-robin sharing of one in-order fp16_mul among NUM_REQ requesters;
// a tag FIFO steers each result back to the requester that issued it.
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 4,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(TAG_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*FP16_W-1:0]   req_a,
  input  logic [NUM_REQ*FP16_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [FP16_W-1:0]           rsp_prod,
  output logic                        mul_in_valid,
  output logic [FP16_W-1:0]           mul_in_a,
  output logic [FP16_W-1:0]           mul_in_b,
  input  logic                        mul_in_ready,
  input  logic                        mul_out_valid,
  input  logic [FP16_W-1:0]           mul_out_prod,
  output logic                        mul_out_ready,
  output logic [CNT_W-1:0]            inflight,
  output logic                        err_orphan
);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("fp16_mul_arbiter: NUM_REQ must be 2..8");
    end
    if (TAG_DEPTH < MUL_INFLIGHT || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fp16_mul_arbiter: TAG_DEPTH must be a power of two >= MUL_INFLIGHT");
    end
  endgenerate

  logic [ID_W-1:0]   r_ptr;
  logic              r_err_orphan;
  logic [ID_W-1:0]   w_win;
  logic [ID_W:0]     w_idx;
  logic              w_any;
  logic              w_can_issue;
  logic              w_fire;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ID_W-1:0]   w_head;
  logic [FP16_W-1:0] w_a [NUM_REQ];
  logic [FP16_W-1:0] w_b [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ops
      assign w_a[gi] = req_a[gi*FP16_W +: FP16_W];
      assign w_b[gi] = req_b[gi*FP16_W +: FP16_W];
    end
  endgenerate

  // Scan from the far end back toward ptr so the last hit is the nearest one.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      if (req_valid[w_idx[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_can_issue  = w_any && !w_full;
  assign w_fire       = w_can_issue && mul_in_ready;
  assign mul_in_valid = w_can_issue;
  assign mul_in_a     = w_a[w_win];
  assign mul_in_b     = w_b[w_win];

  always_comb begin
    req_ready = '0;
    if (w_fire) req_ready[w_win] = 1'b1;
  end

  // An empty FIFO means any result is an orphan; accept it so the pipeline drains.
  always_comb begin
    rsp_valid     = '0;
    mul_out_ready = mul_out_valid;
    if (!w_empty) begin
      rsp_valid[w_head] = mul_out_valid;
      mul_out_ready     = rsp_ready[w_head];
    end
  end

  assign rsp_prod = mul_out_prod;
  assign w_pop    = mul_out_valid && mul_out_ready && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_fire) r_ptr <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
      if (mul_out_valid && w_empty) r_err_orphan <= 1'b1;
    end
  end

  assign err_orphan = r_err_orphan;

  fp16_tag_fifo #(
    .W     (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fire),
    .i_pop   (w_pop),
    .i_data  (w_win),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (inflight)
  );

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Randomized bench: a mock in-order multiplier plus a queue-based reference of the arbiter.
module tb_fp16_mul_arbiter;
  import fp16_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int TAG_DEPTH = 4;
  localparam int MOCK_CAP  = 6;
  localparam int CNT_W     = $clog2(TAG_DEPTH) + 1;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*FP16_W-1:0] req_a, req_b;
  logic [FP16_W-1:0]         rsp_prod, mul_in_a, mul_in_b, mul_out_prod;
  logic                      mul_in_valid, mul_in_ready, mul_out_valid, mul_out_ready;
  logic [CNT_W-1:0]          inflight;
  logic                      err_orphan;

  always #5 clk = ~clk;

  fp16_mul_arbiter #(.NUM_REQ(NUM_REQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prod(rsp_prod),
    .mul_in_valid(mul_in_valid), .mul_in_a(mul_in_a), .mul_in_b(mul_in_b),
    .mul_in_ready(mul_in_ready), .mul_out_valid(mul_out_valid),
    .mul_out_prod(mul_out_prod), .mul_out_ready(mul_out_ready),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] prod;
  } ent_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: outstanding issues in order, priority pointer, sticky error.
  ent_t        m_tags [$];
  int          m_ptr;
  bit          m_err;
  // Mock multiplier: in-order, arbitrary latency, product = a + b - 0x3C00.
  logic [15:0] mock_q [$];
  logic [15:0] op_a [NUM_REQ];
  logic [15:0] op_b [NUM_REQ];
  int          grants [$];

  logic [NUM_REQ-1:0] k_rv, k_rr;
  bit                 k_in_rdy, k_out_en, k_orphan;
  logic [NUM_REQ-1:0] last_rsp_valid;
  logic [15:0]        last_rsp_prod;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    int w;
    bit can;
    bit exp_mor;
    logic [NUM_REQ-1:0] exp_rr, exp_rsp;
    ent_t e;
    logic [15:0] p;
    @(negedge clk);
    req_valid = k_rv;
    rsp_ready = k_rr;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[16*i +: 16] = op_a[i];
      req_b[16*i +: 16] = op_b[i];
    end
    mul_in_ready = k_in_rdy && (mock_q.size() < MOCK_CAP);
    if (k_orphan) begin
      mul_out_valid = 1'b1;
      mul_out_prod  = 16'hBEEF;
    end else if (k_out_en && mock_q.size() > 0) begin
      mul_out_valid = 1'b1;
      mul_out_prod  = mock_q[0];
    end else begin
      mul_out_valid = 1'b0;
      mul_out_prod  = 16'h0000;
    end
    #1;
    w = -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (w < 0 && k_rv[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
    can = (w >= 0) && (m_tags.size() < TAG_DEPTH);
    exp_rr = '0;
    if (can && mul_in_ready) exp_rr[w] = 1'b1;
    check_eq("mul_in_valid", mul_in_valid, can);
    check_eq("req_ready", req_ready, exp_rr);
    if (can) begin
      check_eq("mul_in_a", mul_in_a, op_a[w]);
      check_eq("mul_in_b", mul_in_b, op_b[w]);
    end
    exp_rsp = '0;
    if (m_tags.size() > 0) begin
      if (mul_out_valid) exp_rsp[m_tags[0].id] = 1'b1;
      exp_mor = k_rr[m_tags[0].id];
    end else begin
      exp_mor = mul_out_valid;
    end
    check_eq("rsp_valid", rsp_valid, exp_rsp);
    check_eq("mul_out_ready", mul_out_ready, exp_mor);
    check_eq("inflight", inflight, m_tags.size());
    check_eq("err_orphan", err_orphan, m_err);
    if (mul_out_valid) check_eq("rsp_prod", rsp_prod, mul_out_prod);
    if (rst_n) begin
      // Mock multiplier follows what the DUT actually does.
      if (mul_out_valid && mul_out_ready && !k_orphan && mock_q.size() > 0) void'(mock_q.pop_front());
      if (mul_in_valid && mul_in_ready) mock_q.push_back(mul_in_a + mul_in_b - 16'h3C00);
      // Reference update follows the expected behaviour.
      if (mul_out_valid && exp_mor) begin
        if (m_tags.size() > 0) begin
          e = m_tags.pop_front();
          check_eq("rsp_route_prod", rsp_prod, e.prod);
          last_rsp_valid = rsp_valid;
          last_rsp_prod  = rsp_prod;
        end else begin
          m_err = 1'b1;
        end
      end
      if (can && mul_in_ready) begin
        p = op_a[w] + op_b[w] - 16'h3C00;
        m_tags.push_back('{id: 3'(w), prod: p});
        grants.push_back(w);
        m_ptr = (w + 1) % NUM_REQ;
        op_a[w] = 16'($urandom);
        op_b[w] = 16'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    k_rv = '0; k_orphan = 1'b0; k_out_en = 1'b0;
    @(negedge clk);
    req_valid = '0;
    mul_out_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_inflight", inflight, 0);
    check_eq("rst_err_orphan", err_orphan, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_mul_out_ready", mul_out_ready, 0);
    m_tags.delete();
    mock_q.delete();
    m_ptr = 0;
    m_err = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    k_rv = '0; k_rr = '1; k_out_en = 1'b1; k_orphan = 1'b0;
    while (m_tags.size() > 0 && n < 100) begin
      step();
      n++;
    end
    check_eq("drain_in_budget", (n < 100), 1);
    step();
    check_eq("drain_inflight", inflight, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = 16'($urandom);
      op_b[i] = 16'($urandom);
    end
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    mul_in_ready = 1'b0; mul_out_valid = 1'b0; mul_out_prod = '0;
    k_rv = '0; k_rr = '1; k_in_rdy = 1'b1; k_out_en = 1'b1; k_orphan = 1'b0;
    m_ptr = 0; m_err = 1'b0;
    last_rsp_valid = '0; last_rsp_prod = '0;
    do_reset();

    // Single requester 2: 1.0 * 2.0
    op_a[2] = 16'h3C00; op_b[2] = 16'h4000;
    k_rv = 4'b0100; k_rr = '1; k_in_rdy = 1'b1; k_out_en = 1'b1;
    step();
    k_rv = '0;
    drain();
    check_eq("single_rsp_valid", last_rsp_valid, 4'b0100);
    check_eq("single_prod", last_rsp_prod, 16'h4000);

    // Fairness with everyone valid
    do_reset();
    grants.delete();
    k_rv = '1; k_rr = '1; k_in_rdy = 1'b1; k_out_en = 1'b1;
    repeat (8) step();
    drain();
    check_eq("fair_count", (grants.size() >= 6), 1);
    for (int i = 0; i < 6; i++)
      if (grants.size() > i) check_eq("fair_grant", grants[i], i % NUM_REQ);

    // Requester 0 refuses results: pipeline and tag FIFO fill up
    k_rv = '1; k_rr = 4'b1110; k_in_rdy = 1'b1; k_out_en = 1'b1;
    repeat (12) step();
    check_eq("bp_inflight_full", inflight, TAG_DEPTH);
    check_eq("bp_req_ready", req_ready, 0);
    check_eq("bp_mul_out_ready", mul_out_ready, 0);
    drain();

    // Multiplier backpressure with requesters 1 and 3
    do_reset();
    k_rv = 4'b1010; k_in_rdy = 1'b0; k_out_en = 1'b1;
    repeat (3) begin
      step();
      check_eq("stall_req_ready", req_ready, 0);
      check_eq("stall_valid", mul_in_valid, 1);
      check_eq("stall_a", mul_in_a, op_a[1]);
    end
    grants.delete();
    k_in_rdy = 1'b1;
    step();
    check_eq("stall_grant", (grants.size() > 0) ? grants[0] : -1, 1);
    drain();

    // Orphan result on an empty FIFO
    k_orphan = 1'b1;
    step();
    check_eq("orphan_mul_out_ready", mul_out_ready, 1);
    check_eq("orphan_rsp_valid", rsp_valid, 0);
    k_orphan = 1'b0;
    step();
    check_eq("orphan_flag", err_orphan, 1);

    // Random traffic
    repeat (400) begin
      k_rv     = NUM_REQ'($urandom);
      k_rr     = NUM_REQ'($urandom) | NUM_REQ'($urandom);
      k_in_rdy = ($urandom % 4) != 0;
      k_out_en = ($urandom % 3) != 0;
      step();
    end
    drain();
    check_eq("orphan_sticky", err_orphan, 1);

    // Reset with two operations in flight
    k_rv = 4'b0011; k_in_rdy = 1'b1; k_out_en = 1'b0; k_rr = '1;
    step();
    step();
    k_rv = '0;
    step();
    check_eq("mid_inflight_pre", inflight, 2);
    do_reset();
    grants.delete();
    k_rv = '1; k_in_rdy = 1'b1; k_out_en = 1'b1;
    step();
    check_eq("mid_ptr_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
